udp_tx_sched: RTL

//  Packet-level round-robin scheduler sharing the single outbound UDP/IP TX engine among N_CH user

---
 rtl/udp_tx_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: packet-level round-robin arbiter in front of the UDP TX engine.
// Grants whole packets and latches the header metadata at grant time.
module udp_tx_sched #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH*64-1:0]    s_tdata,
  input  logic [N_CH*8-1:0]     s_tkeep,
  input  logic [N_CH-1:0]       s_tvalid,
  input  logic [N_CH-1:0]       s_tlast,
  output logic [N_CH-1:0]       s_tready,
  input  logic [N_CH*48-1:0]    s_dst_mac,
  input  logic [N_CH*32-1:0]    s_dst_ip,
  input  logic [N_CH*16-1:0]    s_dst_port,
  input  logic [N_CH*16-1:0]    s_src_port,
  output logic [63:0]           m_tdata,
  output logic [7:0]            m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [47:0]           m_dst_mac,
  output logic [31:0]           m_dst_ip,
  output logic [15:0]           m_dst_port,
  output logic [15:0]           m_src_port,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [N_CH*CNT_W-1:0] pkt_cnt
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state, w_nstate;
  logic [2:0]            r_gid, r_last, w_pick;
  logic [N_CH-1:0]       w_req;
  logic                  w_hit, w_done;
  logic [47:0]           r_mac, w_mac;
  logic [31:0]           r_ip, w_ip;
  logic [15:0]           r_dp, w_dp;
  logic [15:0]           r_sp, w_sp;
  logic [N_CH*CNT_W-1:0] r_cnt;

  assign w_req = s_tvalid & ch_en;
  assign w_hit = |w_req;

  // Distance from last_grant+1 (mod N_CH); smallest distance wins.
  always_comb begin : arb
    int d, best;
    w_pick = '0;
    best   = N_CH;
    d      = 0;
    for (int j = 0; j < N_CH; j++) begin
      d = j - int'(r_last) - 1;
      if (d < 0) d = d + N_CH;
      if (w_req[j] && d < best) begin
        best   = d;
        w_pick = 3'(j);
      end
    end
  end

  always_comb begin : meta_sel
    w_mac = '0;
    w_ip  = '0;
    w_dp  = '0;
    w_sp  = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (w_pick == 3'(j)) begin
        w_mac = s_dst_mac[j*48 +: 48];
        w_ip  = s_dst_ip[j*32 +: 32];
        w_dp  = s_dst_port[j*16 +: 16];
        w_sp  = s_src_port[j*16 +: 16];
      end
    end
  end

  always_comb begin : fsm
    w_nstate = r_state;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) w_nstate = S_STREAM;
      end
      S_STREAM: begin
        for (int j = 0; j < N_CH; j++) begin
          if (r_gid == 3'(j)) begin
            m_tdata     = s_tdata[j*64 +: 64];
            m_tkeep     = s_tkeep[j*8 +: 8];
            m_tvalid    = s_tvalid[j];
            m_tlast     = s_tlast[j];
            s_tready[j] = m_tready;
          end
        end
        w_done = m_tvalid & m_tready & m_tlast;
        if (w_done) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gid   <= '0;
      r_last  <= 3'(N_CH - 1);
      r_mac   <= '0;
      r_ip    <= '0;
      r_dp    <= '0;
      r_sp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      if (r_state == S_IDLE && w_hit) begin
        r_gid <= w_pick;
        r_mac <= w_mac;
        r_ip  <= w_ip;
        r_dp  <= w_dp;
        r_sp  <= w_sp;
      end
      if (w_done) begin
        r_last <= r_gid;
        for (int j = 0; j < N_CH; j++) begin
          if (r_gid == 3'(j))
            r_cnt[j*CNT_W +: CNT_W] <= r_cnt[j*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign m_dst_mac  = r_mac;
  assign m_dst_ip   = r_ip;
  assign m_dst_port = r_dp;
  assign m_src_port = r_sp;
  assign grant_id   = r_gid;
  assign busy       = (r_state == S_STREAM);
  assign pkt_cnt    = r_cnt;

endmodule
